// File: rtl/bitscan_encoder_pkg.sv
// Shared types and parameter checks for the bit-scan encoder.
// Imported by the top module.
package bitscan_encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // Checks the parameters without clog2: SIZE must be 1..8 and WIDTH must be 1<<SIZE.
  function automatic bit width_ok(input int size, input int width);
    return (size >= 1) && (size <= 8) && (width == (1 << size));
  endfunction

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit encoder.
// Produces the binary index, a one-hot mask of that bit, and an any-bit-set flag.
module lsb_priority_encoder #(
  parameter int SIZE  = 3,
  parameter int WIDTH = 1 << SIZE
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [SIZE-1:0]  o_idx,
  output logic             o_any,
  output logic [WIDTH-1:0] o_onehot_lsb
);

  logic [WIDTH-1:0] w_onehot;

  // Two's-complement trick isolates the lowest set bit.
  assign w_onehot     = i_vec & (~i_vec + WIDTH'(1));
  assign o_onehot_lsb = w_onehot;
  assign o_any        = |i_vec;

  // OR-tree: each index bit is the OR of the one-hot lines whose position has that bit set.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_onehot[i]) o_idx = o_idx | SIZE'(i);
    end
  end

endmodule

// File: rtl/bitscan_encoder.sv
// Serialises a WIDTH-bit vector into the SIZE-bit indices of its set bits,
// lowest first, one index per out_valid/out_ready handshake.
//
// state | meaning
// IDLE  | no vector held; in_ready high
// SCAN  | pending holds unsent bits; out_valid high
module bitscan_encoder
  import bitscan_encoder_pkg::*;
#(
  parameter int SIZE  = 3,
  parameter int WIDTH = 1 << SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  out_idx,
  output logic             out_last,
  output logic             in_zero
);

  if (!width_ok(SIZE, WIDTH)) begin : g_width_check
    $error("bitscan_encoder: WIDTH must equal 1<<SIZE with SIZE in 1..8");
  end

  state_e           r_state;
  logic [WIDTH-1:0] r_pending;
  logic             r_in_zero;

  logic [SIZE-1:0]  w_idx;
  logic             w_any;
  logic [WIDTH-1:0] w_onehot;
  logic [WIDTH-1:0] w_cleared;
  logic             w_accept;
  logic             w_handshake;

  lsb_priority_encoder #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) u_enc (
    .i_vec        (r_pending),
    .o_idx        (w_idx),
    .o_any        (w_any),
    .o_onehot_lsb (w_onehot)
  );

  assign w_cleared   = r_pending & ~w_onehot;
  assign out_valid   = (r_state == SCAN);
  assign out_idx     = w_idx;
  assign out_last    = w_any && (w_cleared == '0);
  assign in_zero     = r_in_zero;
  assign w_handshake = out_valid && out_ready;
  assign in_ready    = !rst && ((r_state == IDLE) || (w_handshake && out_last));
  assign w_accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_in_zero <= 1'b0;
    end else begin
      r_in_zero <= w_accept && (in_vec == '0);
      // A new vector may overwrite pending in the same cycle its predecessor's last bit leaves.
      if (w_accept && (in_vec != '0)) begin
        r_pending <= in_vec;
        r_state   <= SCAN;
      end else if (w_handshake) begin
        r_pending <= w_cleared;
        if (out_last) r_state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_bitscan_encoder.sv
// Self-checking bench for bitscan_encoder (SIZE=3): directed scenarios followed by
// random traffic, all compared against a queue-based model of emitted indices.
module tb_bitscan_encoder;

  localparam int SIZE  = 3;
  localparam int WIDTH = 1 << SIZE;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  out_idx;
  logic             out_last;
  logic             in_zero;

  int n_checks = 0;
  int n_errors = 0;

  // Model: indices still owed for the current vector, and the zero-accept pulse.
  int q_idx[$];
  bit m_zero = 1'b0;

  always #5 clk = ~clk;

  bitscan_encoder #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .in_zero   (in_zero)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
  task automatic step(input bit r, input bit iv, input logic [WIDTH-1:0] v, input bit ordy);
    bit exp_valid, exp_last, exp_ready, acc;
    int exp_idx;
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    in_vec    = v;
    out_ready = ordy;
    #1;
    exp_valid = (q_idx.size() > 0);
    exp_idx   = exp_valid ? q_idx[0] : 0;
    exp_last  = (q_idx.size() == 1);
    exp_ready = !r && (!exp_valid || (ordy && exp_last));
    check_val("out_valid", 32'(out_valid), 32'(exp_valid));
    check_val("out_idx",   32'(out_idx),   32'(exp_idx));
    check_val("out_last",  32'(out_last),  32'(exp_last));
    check_val("in_zero",   32'(in_zero),   32'(m_zero));
    check_val("in_ready",  32'(in_ready),  32'(exp_ready));
    if (r) begin
      q_idx.delete();
      m_zero = 1'b0;
    end else begin
      acc    = iv && exp_ready;
      m_zero = acc && (v == '0);
      if (exp_valid && ordy) void'(q_idx.pop_front());
      if (acc) begin
        for (int i = 0; i < WIDTH; i++)
          if (v[i]) q_idx.push_back(i);
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    step(0, 0, '0, 0);

    // Three-bit vector at full throughput
    step(0, 1, 8'b1010_0100, 1);
    step(0, 0, 8'h3C, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    // Same vector under backpressure
    step(0, 1, 8'b1010_0100, 0);
    repeat (3) step(0, 0, 8'hFF, 0);
    repeat (4) step(0, 0, '0, 1);

    // Zero vector
    step(0, 1, 8'h00, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    // Back-to-back single-bit vectors
    step(0, 1, 8'h01, 1);
    step(0, 1, 8'h80, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);

    // Full vector
    step(0, 1, 8'hFF, 1);
    repeat (9) step(0, 0, '0, 1);

    // Reset mid-scan after index 2 is handshaken
    step(0, 1, 8'hFF, 1);
    repeat (3) step(0, 0, '0, 1);
    step(1, 0, '0, 1);
    repeat (3) step(0, 0, '0, 1);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        default: v = WIDTH'($urandom);
      endcase
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), v,
           ($urandom_range(0, 3) != 0));
    end
    repeat (10) step(0, 0, '0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
